// File: rtl/pp_stream_deser.sv
// Packs IN_W-bit beats LSB-first into WIDTH-bit words; word valid 1 cycle after its closing beat.
// Only a closing beat stalls, and only while an unconsumed word is held; full rate with out_ready high.
`ifndef WIDTH
`define WIDTH 8
`endif

module pp_stream_deser #(
   parameter int WIDTH = `WIDTH,
   parameter int IN_W  = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_partial
);

   localparam int BEATS = WIDTH / IN_W;
   localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);

   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] word;
   logic             closing;
   logic             accept;

   // in_valid is deliberately kept out of the in_ready path
   assign closing  = (cnt == LAST_CNT) || in_last;
   assign in_ready = !closing || !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

   // acc is zero above the current beat, so word carries no stale upper bits
   always_comb begin
      word = acc;
      word[int'(cnt)*IN_W +: IN_W] = in_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt         <= '0;
         acc         <= '0;
         out_valid   <= 1'b0;
         out_data    <= '0;
         out_partial <= 1'b0;
      end else begin
         if (out_valid && out_ready)
            out_valid <= 1'b0;
         if (accept && closing) begin
            out_data    <= word;
            out_partial <= (cnt != LAST_CNT);
            out_valid   <= 1'b1;
            acc         <= '0;
            cnt         <= '0;
         end else if (accept) begin
            acc <= word;
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_pp_stream_deser.sv
// Bench for pp_stream_deser: directed scenarios plus randomized traffic against a beat-queue word model.
`timescale 1ns/1ps
module tb_pp_stream_deser;

   localparam int W     = 8;
   localparam int IW    = 2;
   localparam int BEATS = W / IW;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid, in_ready, in_last;
   logic [IW-1:0] in_data;
   logic         out_valid, out_ready, out_partial;
   logic [W-1:0] out_data;

   logic         v16, ir16, l16, ov16, r16, op16;
   logic [3:0]   d16;
   logic [15:0]  od16;

   always #5 clk = ~clk;

   pp_stream_deser #(.WIDTH(W), .IN_W(IW)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_partial(out_partial)
   );

   pp_stream_deser #(.WIDTH(16), .IN_W(4)) dut16 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(v16), .in_ready(ir16), .in_data(d16), .in_last(l16),
      .out_valid(ov16), .out_ready(r16), .out_data(od16), .out_partial(op16)
   );

   typedef struct packed {
      logic [W-1:0] d;
      logic         p;
   } exp_t;

   exp_t          exp_q[$];
   logic [IW-1:0] cur_q[$];
   int            n_cmp = 0;
   int            n_bad = 0;
   int            hs_cnt = 0;
   bit            expect_vld = 0;
   bit            held = 0;
   logic [W-1:0]  held_d;
   logic          held_p;
   bit            rnd_ready = 0;
   logic          mon_rdy;
   exp_t          mon_e;
   logic [W-1:0]  mon_w;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor / scoreboard: samples on the falling edge, between active edges
   always @(negedge clk) begin
      if (!rst_n) begin
         cur_q.delete();
         exp_q.delete();
         expect_vld = 0;
         held = 0;
      end else begin
         if (expect_vld) check("latency_valid", out_valid, 1);
         if (held) begin
            check("hold_data", out_data, held_d);
            check("hold_partial", out_partial, held_p);
         end
         mon_rdy = !((cur_q.size() == BEATS - 1) || in_last) || !out_valid || out_ready;
         check("in_ready", in_ready, mon_rdy);
         if (out_valid && out_ready) begin
            hs_cnt++;
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL spurious_word: got 0x%0h, expected no word (t=%0t)", out_data, $time);
            end else begin
               mon_e = exp_q.pop_front();
               check("word_data", out_data, mon_e.d);
               check("word_partial", out_partial, mon_e.p);
            end
         end
         held   = out_valid && !out_ready;
         held_d = out_data;
         held_p = out_partial;
         expect_vld = 0;
         if (in_valid && in_ready) begin
            cur_q.push_back(in_data);
            if (in_last || cur_q.size() == BEATS) begin
               mon_w = '0;
               foreach (cur_q[k]) mon_w |= W'(cur_q[k]) << (IW * k);
               mon_e.d = mon_w;
               mon_e.p = (cur_q.size() < BEATS);
               exp_q.push_back(mon_e);
               cur_q.delete();
               expect_vld = 1;
            end
         end
      end
   end

   always @(posedge clk) begin
      if (rnd_ready) begin
         #1;
         out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   task automatic send(input logic [IW-1:0] d, input logic l);
      int t;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!in_ready && t < 200);
      if (!in_ready) begin
         n_cmp++;
         n_bad++;
         $display("FAIL send_timeout: in_ready=0, required 1 within 200 cycles");
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = IW'($urandom);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete, required finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [3:0] b16 [4];
      int h0;
      int t;
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
      v16 = 1'b0; d16 = '0; l16 = 1'b0; r16 = 1'b1;
      #2;
      check("reset_valid", out_valid, 0);
      check("reset_data", out_data, 0);
      check("reset_partial", out_partial, 0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // 1: full word
      out_ready = 1'b1;
      send(2'd1, 0); send(2'd2, 0); send(2'd3, 0); send(2'd0, 0);
      @(negedge clk);
      check("t1_valid", out_valid, 1);
      check("t1_data", out_data, 8'h39);
      check("t1_partial", out_partial, 0);
      @(posedge clk); #1;

      // 2: held word stalls only the closing beat of the next word
      out_ready = 1'b0;
      send(2'd2, 0); send(2'd2, 0); send(2'd2, 0); send(2'd2, 0);
      send(2'd1, 0); send(2'd1, 0); send(2'd1, 0);
      in_valid = 1'b1; in_data = 2'd3; in_last = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("t2_stall", in_ready, 0);
      end
      @(posedge clk); #1 out_ready = 1'b1;
      @(negedge clk);
      check("t2_accept", in_ready, 1);
      check("t2_drain_w1", out_data, 8'hAA);
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
      check("t2_w2_valid", out_valid, 1);
      check("t2_w2_data", out_data, 8'hD5);
      @(posedge clk); #1;

      // 3: short words and word restart at bit 0
      send(2'd3, 0); send(2'd1, 1);
      @(negedge clk);
      check("t3_data", out_data, 8'h07);
      check("t3_partial", out_partial, 1);
      @(posedge clk); #1;
      send(2'd2, 0); send(2'd0, 0); send(2'd0, 0); send(2'd0, 0);
      @(negedge clk);
      check("t3_next_data", out_data, 8'h02);
      check("t3_next_partial", out_partial, 0);
      @(posedge clk); #1;
      send(2'd3, 1);
      @(negedge clk);
      check("last_beat0_data", out_data, 8'h03);
      check("last_beat0_partial", out_partial, 1);
      @(posedge clk); #1;
      send(2'd0, 0); send(2'd0, 0); send(2'd0, 0); send(2'd1, 1);
      @(negedge clk);
      check("last_beat3_data", out_data, 8'h40);
      check("last_beat3_partial", out_partial, 0);
      @(posedge clk); #1;

      // 4: reset with a held word and a half-built word
      out_ready = 1'b0;
      send(2'd3, 0); send(2'd3, 0); send(2'd3, 0); send(2'd3, 0);
      send(2'd1, 0); send(2'd2, 0);
      rst_n = 1'b0;
      #1;
      check("t4_rst_valid", out_valid, 0);
      check("t4_rst_data", out_data, 0);
      check("t4_rst_partial", out_partial, 0);
      @(negedge clk);
      @(posedge clk); #1 rst_n = 1'b1;
      out_ready = 1'b1;
      send(2'd2, 0); send(2'd1, 0); send(2'd0, 0); send(2'd3, 0);
      @(negedge clk);
      check("t4_clean_data", out_data, 8'hC6);
      check("t4_clean_partial", out_partial, 0);
      @(posedge clk); #1;

      // 5: back-to-back, 40 cycles -> 10 words
      h0 = hs_cnt;
      for (int i = 0; i < 40; i++) begin
         in_valid = 1'b1; in_last = 1'b0; in_data = IW'($urandom);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      check("t5_words", hs_cnt - h0, 10);

      // 6: WIDTH=16, IN_W=4
      b16[0] = 4'hF; b16[1] = 4'h0; b16[2] = 4'hA; b16[3] = 4'h5;
      for (int i = 0; i < 4; i++) begin
         v16 = 1'b1; d16 = b16[i];
         t = 0;
         do begin @(negedge clk); t++; end while (!ir16 && t < 50);
         check("t6_ready", ir16, 1);
         @(posedge clk); #1;
      end
      v16 = 1'b0;
      @(negedge clk);
      check("t6_valid", ov16, 1);
      check("t6_data", od16, 16'h5A0F);
      check("t6_partial", op16, 0);
      @(posedge clk); #1;

      // Random traffic with random backpressure
      rnd_ready = 1;
      for (int i = 0; i < 400; i++) begin
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         send(IW'($urandom), (i == 399) || ($urandom_range(0, 99) < 15));
      end
      rnd_ready = 0;
      @(posedge clk); #2 out_ready = 1'b1;
      repeat (10) begin @(posedge clk); #1; end
      check("drain_empty", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
